// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Core-wide sizing shared by the scheduler blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int NUM_FUS    = 2;

    typedef logic [$clog2(NUM_FUS)-1:0] fu_id_t;

endpackage
`default_nettype wire

// File: rtl/free_return_queue.sv
`default_nettype none
// ============================================================================
// Module      : free_return_queue
// Description : Circular queue of row indices. It accepts several pushes per
//               cycle, in port order, and drains one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module free_return_queue #(
    parameter  int DEPTH    = 8,
    parameter  int NUM_PUSH = 2,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [NUM_PUSH-1:0]                push_en,
    input  logic [NUM_PUSH-1:0][IDX_W-1:0]     push_data,
    output logic                               pop_en,
    output logic [IDX_W-1:0]                   pop_data
);

    localparam int SUM_W = CNT_W + 1;

    logic [IDX_W-1:0]                  mem [DEPTH];
    logic [IDX_W-1:0]                  head;
    logic [IDX_W-1:0]                  tail;
    logic [CNT_W-1:0]                  count;
    logic [CNT_W-1:0]                  push_cnt;
    logic [NUM_PUSH-1:0][IDX_W-1:0]    wr_addr;
    logic [IDX_W-1:0]                  tail_next;
    logic [IDX_W-1:0]                  head_next;
    logic                              do_pop;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum >= SUM_W'(DEPTH))
            sum = sum - SUM_W'(DEPTH);
        return sum[IDX_W-1:0];
    endfunction

    // Each active push lands at tail plus the number of lower-numbered pushes.
    always_comb begin
        push_cnt = '0;
        wr_addr  = '0;
        for (int p = 0; p < NUM_PUSH; p++) begin
            wr_addr[p] = wrap_add(tail, push_cnt);
            if (push_en[p])
                push_cnt = push_cnt + CNT_W'(1);
        end
        tail_next = wrap_add(tail, push_cnt);
        head_next = wrap_add(head, CNT_W'(1));
        do_pop    = (count != '0);
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int p = 0; p < NUM_PUSH; p++) begin
                if (push_en[p])
                    mem[wr_addr[p]] <= push_data[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pop_en   <= 1'b0;
            pop_data <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pop_en   <= 1'b0;
        end else begin
            pop_en   <= do_pop;
            pop_data <= mem[head];
            if (do_pop)
                head <= head_next;
            tail     <= tail_next;
            count    <= count + push_cnt - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_select.sv
`default_nettype none
// ============================================================================
// Module      : issue_select
// Description : Reservation-station issue selector. It picks the oldest ready
//               row for each FU and returns granted rows through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_select
    import core_pkg::*;
#(
    parameter  int NUM_ENTRIES = RS_ENTRIES,
    parameter  int NUM_FU      = NUM_FUS,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int FU_W        = $clog2(NUM_FU)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_en,
    input  logic [IDX_W-1:0]               alloc_index,
    input  logic [FU_W-1:0]                alloc_fu,
    input  logic [NUM_ENTRIES-1:0]         request_vector,
    input  logic [NUM_FU-1:0]              fu_ready,
    input  logic                           flush,
    output logic [NUM_FU-1:0]              grant_en,
    output logic [NUM_FU-1:0][IDX_W-1:0]   grant_index,
    output logic                           free_en,
    output logic [IDX_W-1:0]               free_row_index
);

    logic [NUM_ENTRIES-1:0]               valid;
    logic [FU_W-1:0]                      fu_of [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]               older [NUM_ENTRIES];
    logic [NUM_FU-1:0][NUM_ENTRIES-1:0]   eligible;
    logic [NUM_FU-1:0]                    win_en;
    logic [NUM_FU-1:0][IDX_W-1:0]         win_idx;
    logic [NUM_ENTRIES-1:0]               win_mask;
    logic [NUM_ENTRIES-1:0]               alloc_mask;

    assign alloc_mask = alloc_en ? (NUM_ENTRIES'(1) << alloc_index) : '0;

    // A row wins its FU when no other eligible row on that FU is older.
    always_comb begin
        eligible = '0;
        win_en   = '0;
        win_idx  = '0;
        win_mask = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                eligible[f][i] = valid[i] & request_vector[i] & fu_ready[f] &
                                 (fu_of[i] == FU_W'(f));
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (eligible[f][i] && ((eligible[f] & older[i]) == '0)) begin
                    win_en[f]   = 1'b1;
                    win_idx[f]  = IDX_W'(i);
                    win_mask[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= '0;
            grant_en    <= '0;
            grant_index <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                fu_of[i] <= '0;
                older[i] <= '0;
            end
        end else if (flush) begin
            valid    <= '0;
            grant_en <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                older[i] <= '0;
        end else begin
            grant_en    <= win_en;
            grant_index <= win_idx;
            valid       <= (valid & ~win_mask) | alloc_mask;
            if (alloc_en)
                fu_of[alloc_index] <= alloc_fu;
            // New row is younger than every live row; nobody is younger than it.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc_en && (IDX_W'(i) == alloc_index))
                    older[i] <= valid & ~alloc_mask;
                else if (alloc_en)
                    older[i] <= older[i] & ~alloc_mask;
            end
        end
    end

    free_return_queue #(
        .DEPTH     (NUM_ENTRIES),
        .NUM_PUSH  (NUM_FU)
    ) u_free_return_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push_en   (win_en),
        .push_data (win_idx),
        .pop_en    (free_en),
        .pop_data  (free_row_index)
    );

`ifndef SYNTHESIS
    alloc_to_free_row: assert property (@(posedge clk) disable iff (!rst)
        (alloc_en && !flush) |-> !valid[alloc_index]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_select
// Description : Directed and random checks of issue_select against an
//               age-stamp reference model of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_select;

    logic            clk = 1'b0;
    logic            rst;
    logic            alloc_en;
    logic [2:0]      alloc_index;
    logic [0:0]      alloc_fu;
    logic [7:0]      request_vector;
    logic [1:0]      fu_ready;
    logic            flush;
    logic [1:0]      grant_en;
    logic [1:0][2:0] grant_index;
    logic            free_en;
    logic [2:0]      free_row_index;

    int errors = 0;
    int checks = 0;

    // Reference state: liveness, FU and allocation order stamp per row.
    bit m_valid [8];
    int m_fu    [8];
    int m_stamp [8];
    int seq = 0;
    int fq [$];
    bit e_gen  [2];
    int e_gidx [2];
    bit e_fen;
    int e_fidx;

    issue_select #(
        .NUM_ENTRIES    (8),
        .NUM_FU         (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_en       (alloc_en),
        .alloc_index    (alloc_index),
        .alloc_fu       (alloc_fu),
        .request_vector (request_vector),
        .fu_ready       (fu_ready),
        .flush          (flush),
        .grant_en       (grant_en),
        .grant_index    (grant_index),
        .free_en        (free_en),
        .free_row_index (free_row_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        fq.delete();
        e_gen[0] = 1'b0;
        e_gen[1] = 1'b0;
        e_fen    = 1'b0;
    endtask

    // Expected registered outputs from pre-edge model state and current inputs.
    task automatic predict();
        int win [2];
        if (flush) begin
            model_reset();
            return;
        end
        for (int f = 0; f < 2; f++) begin
            win[f] = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i] && request_vector[i] && fu_ready[f] && m_fu[i] == f &&
                    (win[f] < 0 || m_stamp[i] < m_stamp[win[f]]))
                    win[f] = i;
            end
            e_gen[f] = (win[f] >= 0);
            if (win[f] >= 0) e_gidx[f] = win[f];
        end
        if (fq.size() > 0) begin
            e_fen  = 1'b1;
            e_fidx = fq.pop_front();
        end else begin
            e_fen = 1'b0;
        end
        for (int f = 0; f < 2; f++) begin
            if (win[f] >= 0) begin
                fq.push_back(win[f]);
                m_valid[win[f]] = 1'b0;
            end
        end
        if (alloc_en) begin
            m_valid[alloc_index] = 1'b1;
            m_fu[alloc_index]    = int'(alloc_fu);
            m_stamp[alloc_index] = seq;
            seq++;
        end
    endtask

    task automatic compare();
        for (int f = 0; f < 2; f++) begin
            check($sformatf("grant_en%0d", f), 32'(grant_en[f]), 32'(e_gen[f]));
            if (e_gen[f])
                check($sformatf("grant_index%0d", f), 32'(grant_index[f]), 32'(e_gidx[f]));
        end
        check("free_en", 32'(free_en), 32'(e_fen));
        if (e_fen)
            check("free_row_index", 32'(free_row_index), 32'(e_fidx));
    endtask

    task automatic step(input logic a_en, input int a_idx, input int a_fu,
                        input logic [7:0] req, input logic [1:0] fr, input logic fl);
        alloc_en       = a_en;
        alloc_index    = a_idx[2:0];
        alloc_fu       = 1'(a_fu);
        request_vector = req;
        fu_ready       = fr;
        flush          = fl;
        predict();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n, input logic [7:0] req, input logic [1:0] fr);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, req, fr, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant_en"}, 32'(grant_en), 32'd0);
        check({tag, "_grant_index"}, 32'(grant_index), 32'd0);
        check({tag, "_free_en"}, 32'(free_en), 32'd0);
        check({tag, "_free_row_index"}, 32'(free_row_index), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int free_rows [$];
        logic a_en;
        int a_idx;

        rst = 1'b0;
        alloc_en = 1'b0; alloc_index = '0; alloc_fu = '0;
        request_vector = '0; fu_ready = '0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b1;

        // Three FU0 rows granted oldest-first, one per cycle.
        step(1'b1, 5, 0, 8'hFF, 2'b01, 1'b0);
        step(1'b1, 2, 0, 8'hFF, 2'b01, 1'b0);
        step(1'b1, 7, 0, 8'hFF, 2'b01, 1'b0);
        idle(6, 8'hFF, 2'b01);

        // Simultaneous grants on both FUs, freed in FU order.
        step(1'b1, 3, 0, 8'h00, 2'b11, 1'b0);
        step(1'b1, 4, 1, 8'h00, 2'b11, 1'b0);
        step(1'b0, 0, 0, 8'h18, 2'b11, 1'b0);
        idle(4, 8'h00, 2'b11);

        // FU0 busy for four cycles holds row 1 back.
        step(1'b1, 1, 0, 8'h00, 2'b10, 1'b0);
        idle(4, 8'h02, 2'b10);
        step(1'b0, 0, 0, 8'h02, 2'b11, 1'b0);
        idle(3, 8'h00, 2'b11);

        // Request in the allocation cycle is too early.
        step(1'b1, 6, 0, 8'h40, 2'b11, 1'b0);
        step(1'b0, 0, 0, 8'h40, 2'b11, 1'b0);
        idle(3, 8'h00, 2'b11);

        // Fill, drain, wrap and refill the whole station.
        for (int i = 0; i < 8; i++) step(1'b1, i, i % 2, 8'h00, 2'b11, 1'b0);
        idle(12, 8'hFF, 2'b11);
        for (int i = 7; i >= 0; i--) step(1'b1, i, i / 4, 8'h00, 2'b11, 1'b0);
        idle(12, 8'hFF, 2'b11);

        // Flush with live rows and pending frees.
        for (int i = 0; i < 6; i++) step(1'b1, i, i % 2, 8'h00, 2'b11, 1'b0);
        step(1'b0, 0, 0, 8'h03, 2'b11, 1'b0);
        step(1'b0, 0, 0, 8'hFF, 2'b11, 1'b1);
        idle(3, 8'hFF, 2'b11);

        // Asynchronous reset while a grant is being presented.
        step(1'b1, 2, 1, 8'h00, 2'b00, 1'b0);
        step(1'b0, 0, 0, 8'h04, 2'b10, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_cleared("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4, 1, 8'h10, 2'b11, 1'b0);
        idle(3, 8'h10, 2'b11);

        for (int n = 0; n < 400; n++) begin
            free_rows.delete();
            for (int i = 0; i < 8; i++) if (!m_valid[i]) free_rows.push_back(i);
            a_en  = ($urandom_range(0, 1) == 1) && (free_rows.size() > 0);
            a_idx = a_en ? free_rows[$urandom_range(0, free_rows.size() - 1)] : 0;
            step(a_en, a_idx, $urandom_range(0, 1), 8'($urandom), 2'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        idle(12, 8'hFF, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
